// File: rtl/fft16_addr_ctrl.sv
// fft16_addr_ctrl
//   Control and address generator for the in-place radix-2 DIT butterfly
//   datapath of a 2**N_LOG2-point FFT. It walks N_LOG2 stages of N/2
//   butterflies and issues the operand read pair and twiddle index for each
//   butterfly. The write-back addresses are delayed by LATENCY cycles so they
//   line up with the datapath results. After each stage it inserts a
//   LATENCY-cycle drain, so the next stage never reads a result that has not
//   been written yet.
//
// Optional feature macro: FFT16_ADDR_CTRL_BITREV_LOAD_EN
//   When defined, a LOAD state sits between IDLE and READ. In LOAD the block
//   accepts N input samples and issues their bit-reversed RAM addresses.
//   When undefined, the RAM must be preloaded in bit-reversed order.
//
// Ports
//   i_clk, i_rst       clock; synchronous active-high reset
//   i_start            start one transform (sampled in IDLE only)
//   i_stall            hold read issue (READ only)
//   o_busy / o_done    busy in LOAD/READ/DRAIN; one-cycle completion pulse
//   o_stage            current stage (0 in IDLE/DONE)
//   o_rd_valid         read pair valid this cycle
//   o_rd_addr_a/_b     top/bottom operand addresses
//   o_tw_idx           twiddle ROM index
//   o_wr_en            write both results this cycle
//   o_wr_addr_a/_b     read addresses delayed LATENCY cycles
//   i_in_valid         (load feature) input sample valid
//   o_ld_en/o_ld_addr  (load feature) sample write enable / bit-reversed addr
module fft16_addr_ctrl #(
  parameter int unsigned N_LOG2  = 4,
  parameter int unsigned LATENCY = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stall,
`ifdef FFT16_ADDR_CTRL_BITREV_LOAD_EN
  input  logic              i_in_valid,
  output logic              o_ld_en,
  output logic [N_LOG2-1:0] o_ld_addr,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic [N_LOG2-1:0] o_stage,
  output logic              o_rd_valid,
  output logic [N_LOG2-1:0] o_rd_addr_a,
  output logic [N_LOG2-1:0] o_rd_addr_b,
  output logic [N_LOG2-2:0] o_tw_idx,
  output logic              o_wr_en,
  output logic [N_LOG2-1:0] o_wr_addr_a,
  output logic [N_LOG2-1:0] o_wr_addr_b
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [N_LOG2-1:0] SLAST  = N_LOG2'(N_LOG2 - 1);
  localparam logic [3:0]        DLAST  = 4'(LATENCY - 1);
  localparam logic [N_LOG2-1:0] S_ONE  = N_LOG2'(1);
  localparam logic [N_LOG2-2:0] K_ONE  = (N_LOG2-1)'(1);

  state_t            r_state;
  logic [N_LOG2-1:0] r_s;
  logic [N_LOG2-2:0] r_k;
  logic [3:0]        r_dcnt;

  logic              r_pv [LATENCY];
  logic [N_LOG2-1:0] r_pa [LATENCY];
  logic [N_LOG2-1:0] r_pb [LATENCY];

  logic              w_in_read;
  logic              w_rd_valid;
  logic [N_LOG2-2:0] w_mask;
  logic [N_LOG2-2:0] w_pos;
  logic [N_LOG2-2:0] w_grp;
  logic [N_LOG2-2:0] w_tw;
  logic [N_LOG2-1:0] w_span;
  logic [N_LOG2-1:0] w_addr_a;
  logic [N_LOG2-1:0] w_addr_b;

`ifdef FFT16_ADDR_CTRL_BITREV_LOAD_EN
  logic [N_LOG2-1:0] r_ld_cnt;

  function automatic logic [N_LOG2-1:0] f_bitrev(input logic [N_LOG2-1:0] v);
    for (int unsigned i = 0; i < N_LOG2; i++) f_bitrev[i] = v[N_LOG2-1-i];
  endfunction

  assign o_ld_en   = (r_state == S_LOAD) && i_in_valid;
  assign o_ld_addr = (r_state == S_LOAD) ? f_bitrev(r_ld_cnt) : '0;
`endif

  // Butterfly k of stage s: pos = k mod span, grp = k / span.
  // addr_a = grp*2*span + pos. The mask keeps pos within N_LOG2-1 bits,
  // including the last stage, where span itself needs N_LOG2 bits.
  always_comb begin
    w_mask   = ~({(N_LOG2-1){1'b1}} << r_s);
    w_pos    = r_k & w_mask;
    w_grp    = r_k >> r_s;
    w_tw     = w_pos << (SLAST - r_s);
    w_span   = S_ONE << r_s;
    w_addr_a = ({w_grp, 1'b0} << r_s) | {1'b0, w_pos};
    w_addr_b = w_addr_a | w_span;
  end

  assign w_in_read   = (r_state == S_READ);
  assign w_rd_valid  = w_in_read && !i_stall;
  assign o_rd_valid  = w_rd_valid;
  assign o_rd_addr_a = w_in_read ? w_addr_a : '0;
  assign o_rd_addr_b = w_in_read ? w_addr_b : '0;
  assign o_tw_idx    = w_in_read ? w_tw : '0;
  assign o_busy      = (r_state == S_LOAD) || w_in_read || (r_state == S_DRAIN);
  assign o_done      = (r_state == S_DONE);
  assign o_stage     = r_s;
  assign o_wr_en     = r_pv[LATENCY-1];
  assign o_wr_addr_a = r_pa[LATENCY-1];
  assign o_wr_addr_b = r_pb[LATENCY-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_k     <= '0;
      r_dcnt  <= '0;
`ifdef FFT16_ADDR_CTRL_BITREV_LOAD_EN
      r_ld_cnt <= '0;
`endif
      for (int unsigned i = 0; i < LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      // The write pipeline advances every cycle, so stalls never hold back
      // results that are already in flight.
      r_pv[0] <= w_rd_valid;
      r_pa[0] <= w_in_read ? w_addr_a : '0;
      r_pb[0] <= w_in_read ? w_addr_b : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_s <= '0;
            r_k <= '0;
`ifdef FFT16_ADDR_CTRL_BITREV_LOAD_EN
            r_ld_cnt <= '0;
            r_state  <= S_LOAD;
`else
            r_state  <= S_READ;
`endif
          end
        end
`ifdef FFT16_ADDR_CTRL_BITREV_LOAD_EN
        S_LOAD: begin
          if (i_in_valid) begin
            r_ld_cnt <= r_ld_cnt + S_ONE;
            if (r_ld_cnt == '1) r_state <= S_READ;
          end
        end
`endif
        S_READ: begin
          if (!i_stall) begin
            r_k <= r_k + K_ONE;
            if (r_k == '1) begin
              r_dcnt  <= '0;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_dcnt <= r_dcnt + 4'd1;
          if (r_dcnt == DLAST) begin
            r_k <= '0;
            if (r_s == SLAST) begin
              r_s     <= '0;
              r_state <= S_DONE;
            end else begin
              r_s     <= r_s + S_ONE;
              r_state <= S_READ;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
